branch_predict_unit: RTL and testbench
======================================

Name: branch_predict_unit

Overview:
- Parametrised successor to the combinational branch/PC-select decoder.
- Adds a direct-mapped BTB with 2-bit saturating BHT counters: predicts in IF, resolves in EX.
- Resolution produces a redirect with a correct PC, updates the tables, and keeps saturating performance counters.
- Sits between IF (PC mux) and EX (ALU zero flag, target adder).

Parameters:
XLEN, 32, address/data width
DEPTH, 16, BTB/BHT entries; power of two, >= 2; IDX_W = $clog2(DEPTH) is a localparam
CNT_W, 32, performance counter width

Ports:
clk  input  1  clock
rst_n  input  1  synchronous active-low reset
if_pc  input  XLEN  fetch PC
pred_taken  output  1  IF prediction: taken
pred_target  output  XLEN  IF predicted target (if_pc+4 when not taken)
ex_valid  input  1  EX holds a valid instruction
ex_stall  input  1  EX frozen; no resolution this cycle
ex_pc  input  XLEN  PC of EX instruction
ex_branch  input  2  00 none, 01 jalr, 10 b-type, 11 jal
ex_zero_flag  input  1  ALU condition true
ex_target  input  XLEN  computed target (pc+imm, or rs1+imm for jalr)
ex_pred_taken  input  1  prediction carried down the pipe
ex_pred_target  input  XLEN  predicted target carried down the pipe
redirect  output  1  mispredict; flush IF/ID, load redirect_pc
redirect_pc  output  XLEN  correct next PC
branch_cnt  output  CNT_W  resolved branches/jumps
mispred_cnt  output  CNT_W  mispredictions

Behaviour:
- Index = pc[IDX_W+1:2]; tag = pc[XLEN-1:IDX_W+2].
- Entry fields: valid, tag, target, is_jump, ctr[1:0].
- Prediction (combinational from registered state, zero latency):
  - hit = valid & tag match.
  - pred_taken = hit & (is_jump | ctr[1]).
  - pred_target = pred_taken ? target : if_pc+4.
- Resolve (combinational), gated by res = ex_valid & ~ex_stall & ex_branch != 00:
  - actual = (b & zero) | jal | jalr.
  - mispredict = actual != ex_pred_taken, or (actual & ex_pred_taken & ex_target != ex_pred_target).
  - redirect = res & mispredict.
  - redirect_pc = actual ? ex_target : ex_pc+4. Defined whenever res; don't-care otherwise.
  - Non-branch, invalid, or stalled: redirect = 0, no state change.
- Update at the clock edge when res:
  - Taken with BTB hit: target <= ex_target. For b-type, ctr increments, saturating at 11.
  - Taken with miss: allocate/overwrite the entry:
    - valid = 1, tag, target = ex_target.
    - is_jump = (jal | jalr).
    - ctr = 10.
  - b-type not taken with hit: ctr decrements, saturating at 00.
  - b-type not taken with miss: no change.
  - jal/jalr never touch ctr except on allocate.
- Counters:
  - branch_cnt += 1 on every res.
  - mispred_cnt += 1 on every redirect.
  - Both saturate at all-ones; no wrap.
- Same-index IF read and EX write in one cycle: IF sees the pre-update value. No bypass.
- Reset (rst_n = 0 at a clock edge):
  - All valid = 0, ctr = 01, targets/tags = 0, counters = 0.
  - Outputs after reset: pred_taken = 0, pred_target = if_pc+4, redirect = 0, branch_cnt = 0, mispred_cnt = 0.
  - Reset mid-operation discards any same-cycle update.
- ex_stall held: the same instruction resolves exactly once, on the first unstalled cycle.

Decomposition:
- Shared package (branch_pkg):
  - Branch encodings: none_branch, jalr_branch, b_branch, j_branch.
  - PC-select constants: pc_4, pc_imm, pc_imm_sr1.
  - btb_entry_t struct.
  - 2-bit counter saturating inc/dec functions.
- One sub-module: sat_counter (CNT_W-wide saturating incrementer, sync active-low clear), instantiated twice for the performance counters.

Test Plan:
- Reset, then if_pc=0x100 -> pred_taken=0, pred_target=0x104; both counters 0.
- b at 0x100 taken to 0x180, pred 0 -> redirect=1, redirect_pc=0x180, mispred_cnt=1. Next cycle if_pc=0x100 -> pred_taken=1, pred_target=0x180.
- Same b resolved not-taken twice: ctr 10->01->00; if_pc=0x100 -> pred_taken=0. Three further not-taken resolutions keep ctr at 00.
- jalr at 0x200, first target 0x300 then 0x340, predicted 0x300 -> second resolve: redirect=1, redirect_pc=0x340, entry target updated.
- Aliasing: 0x100 and 0x100+4*DEPTH both taken -> second overwrites the entry; if_pc=0x100 -> pred_taken=0.
- ex_stall=1 for 3 cycles with a valid jal -> no redirect, branch_cnt unchanged; unstall -> exactly one increment. Reset asserted with res=1 -> no allocation, counters 0.

Source files
------------

// File: rtl/branch_pkg.sv
// Shared types and helpers for the branch prediction unit: branch encodings,
// PC-select codes, the BTB/BHT entry layout and 2-bit counter arithmetic.
package branch_pkg;

  // EX-stage branch kind, as carried on ex_branch
  typedef enum logic [1:0] {
    none_branch = 2'b00,
    jalr_branch = 2'b01,
    b_branch    = 2'b10,
    j_branch    = 2'b11
  } branch_e;

  // Source of the corrected next PC on resolution
  typedef enum logic [1:0] {
    pc_4       = 2'd0,  // fall-through, pc+4
    pc_imm     = 2'd1,  // pc-relative target (b-type / jal)
    pc_imm_sr1 = 2'd2   // register-relative target (jalr)
  } pc_sel_e;

  // Tag/target fields are sized for the widest supported XLEN; the unit
  // zero-extends on write and truncates on read, so unused upper bits of a
  // narrower configuration are constant and get trimmed.
  localparam int BTB_ADDR_W = 64;

  localparam logic [1:0] CTR_RESET = 2'b01;  // weakly not-taken
  localparam logic [1:0] CTR_ALLOC = 2'b10;  // weakly taken

  typedef struct packed {
    logic                  valid;
    logic [BTB_ADDR_W-1:0] tag;
    logic [BTB_ADDR_W-1:0] target;
    logic                  is_jump;
    logic [1:0]            ctr;
  } btb_entry_t;

  localparam btb_entry_t BTB_ENTRY_RESET = '{
    valid:   1'b0,
    tag:     '0,
    target:  '0,
    is_jump: 1'b0,
    ctr:     CTR_RESET
  };

  function automatic logic [1:0] ctr_inc(input logic [1:0] c);
    return (c == 2'b11) ? c : c + 2'b01;
  endfunction

  function automatic logic [1:0] ctr_dec(input logic [1:0] c);
    return (c == 2'b00) ? c : c - 2'b01;
  endfunction

endpackage

// File: rtl/branch_predict_unit_if.sv
// IF/EX-facing bundle of the branch prediction unit. The pipeline is the
// master; the prediction unit is the slave.
interface branch_predict_unit_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
);
  logic [XLEN-1:0]  if_pc;
  logic             pred_taken;
  logic [XLEN-1:0]  pred_target;

  logic             ex_valid;
  logic             ex_stall;
  logic [XLEN-1:0]  ex_pc;
  logic [1:0]       ex_branch;
  logic             ex_zero_flag;
  logic [XLEN-1:0]  ex_target;
  logic             ex_pred_taken;
  logic [XLEN-1:0]  ex_pred_target;

  logic             redirect;
  logic [XLEN-1:0]  redirect_pc;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] mispred_cnt;

  modport master (
    output if_pc, ex_valid, ex_stall, ex_pc, ex_branch, ex_zero_flag,
           ex_target, ex_pred_taken, ex_pred_target,
    input  pred_taken, pred_target, redirect, redirect_pc,
           branch_cnt, mispred_cnt
  );

  modport slave (
    input  if_pc, ex_valid, ex_stall, ex_pc, ex_branch, ex_zero_flag,
           ex_target, ex_pred_taken, ex_pred_target,
    output pred_taken, pred_target, redirect, redirect_pc,
           branch_cnt, mispred_cnt
  );
endinterface

// File: rtl/branch_predict_unit_sat_counter.sv
// Saturating event counter with synchronous active-low clear. Sticks at
// all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next value: +1 unless already saturated
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // Counter register; clear wins over a same-cycle increment
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
endmodule

// File: rtl/branch_predict_unit.sv
// Direct-mapped BTB with 2-bit BHT counters. Predicts in IF from registered
// state, resolves in EX, redirects on mispredict and counts events.
module branch_predict_unit #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 16,
  parameter int CNT_W = 32
) (
  input logic                  clk,
  input logic                  rst_n,
  branch_predict_unit_if.slave bus
);
  import branch_pkg::*;

  localparam int IDX_W = $clog2(DEPTH);
  localparam int TAG_W = XLEN - IDX_W - 2;

  btb_entry_t       btb_q [DEPTH];
  btb_entry_t       btb_d [DEPTH];

  logic [IDX_W-1:0] if_idx;
  logic [IDX_W-1:0] ex_idx;
  logic [TAG_W-1:0] if_tag;
  logic [TAG_W-1:0] ex_tag;
  btb_entry_t       if_entry;
  btb_entry_t       ex_entry;
  logic             if_hit;
  logic             ex_hit;
  logic             pred_taken;
  logic [XLEN-1:0]  pred_target;

  branch_e          ex_kind;
  logic             is_b;
  logic             is_jal;
  logic             is_jalr;
  logic             res;
  logic             actual;
  logic             mispredict;
  pc_sel_e          pc_sel;
  logic [XLEN-1:0]  redirect_pc;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] mispred_cnt;

  assign if_idx  = bus.if_pc[IDX_W+1:2];
  assign if_tag  = bus.if_pc[XLEN-1:IDX_W+2];
  assign ex_idx  = bus.ex_pc[IDX_W+1:2];
  assign ex_tag  = bus.ex_pc[XLEN-1:IDX_W+2];
  assign ex_kind = branch_e'(bus.ex_branch);

  // IF lookup: reads registered table only, so a same-index EX write this
  // cycle is not visible until next cycle
  always_comb begin
    if_entry    = btb_q[if_idx];
    if_hit      = if_entry.valid && (if_entry.tag == BTB_ADDR_W'(if_tag));
    pred_taken  = if_hit && (if_entry.is_jump || if_entry.ctr[1]);
    pred_target = pred_taken ? XLEN'(if_entry.target) : bus.if_pc + XLEN'(4);
  end

  // EX resolution: actual outcome, mispredict and next-PC source
  always_comb begin
    ex_entry   = btb_q[ex_idx];
    ex_hit     = ex_entry.valid && (ex_entry.tag == BTB_ADDR_W'(ex_tag));
    is_b       = (ex_kind == b_branch);
    is_jal     = (ex_kind == j_branch);
    is_jalr    = (ex_kind == jalr_branch);
    res        = bus.ex_valid && !bus.ex_stall && (ex_kind != none_branch);
    actual     = (is_b && bus.ex_zero_flag) || is_jal || is_jalr;
    mispredict = (actual != bus.ex_pred_taken) ||
                 (actual && bus.ex_pred_taken &&
                  (bus.ex_target != bus.ex_pred_target));
    if (!actual) begin
      pc_sel = pc_4;
    end else if (is_jalr) begin
      pc_sel = pc_imm_sr1;
    end else begin
      pc_sel = pc_imm;
    end
  end

  // Corrected PC mux; the EX adder has already formed both kinds of target
  always_comb begin
    case (pc_sel)
      pc_imm, pc_imm_sr1: redirect_pc = bus.ex_target;
      default:            redirect_pc = bus.ex_pc + XLEN'(4);
    endcase
  end

  // Table update: refresh target / train counter on hit, allocate on a
  // taken miss, leave not-taken misses alone
  always_comb begin
    btb_d = btb_q;
    if (res) begin
      if (actual) begin
        if (ex_hit) begin
          btb_d[ex_idx].target = BTB_ADDR_W'(bus.ex_target);
          if (is_b) begin
            btb_d[ex_idx].ctr = ctr_inc(ex_entry.ctr);
          end
        end else begin
          btb_d[ex_idx] = '{
            valid:   1'b1,
            tag:     BTB_ADDR_W'(ex_tag),
            target:  BTB_ADDR_W'(bus.ex_target),
            is_jump: !is_b,
            ctr:     CTR_ALLOC
          };
        end
      end else if (is_b && ex_hit) begin
        btb_d[ex_idx].ctr = ctr_dec(ex_entry.ctr);
      end
    end
  end

  // Table storage; reset clears every entry and drops any pending update
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        btb_q[i] <= BTB_ENTRY_RESET;
      end
    end else begin
      btb_q <= btb_d;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_branch_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (res),
    .count (branch_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_mispred_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (res && mispredict),
    .count (mispred_cnt)
  );

  assign bus.pred_taken  = pred_taken;
  assign bus.pred_target = pred_target;
  assign bus.redirect    = res && mispredict;
  assign bus.redirect_pc = redirect_pc;
  assign bus.branch_cnt  = branch_cnt;
  assign bus.mispred_cnt = mispred_cnt;
endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit: a vector table stepped one cycle
// per record, plus hand-written stall, reset and counter-saturation sequences.
module tb_branch_predict_unit;
  import branch_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  branch_predict_unit_if #(.XLEN(32), .CNT_W(32)) bus ();

  branch_predict_unit #(.XLEN(32), .DEPTH(16), .CNT_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic       sc_rst_n;
  logic       sc_inc;
  logic [2:0] sc_count;

  sat_counter #(.CNT_W(3)) u_sc (
    .clk   (clk),
    .rst_n (sc_rst_n),
    .inc   (sc_inc),
    .count (sc_count)
  );

  int tests  = 0;
  int failed = 0;

  typedef struct {
    logic [31:0] if_pc;
    logic [31:0] valid;
    logic [31:0] br;
    logic [31:0] zero;
    logic [31:0] ex_pc;
    logic [31:0] ex_tgt;
    logic [31:0] ep_taken;
    logic [31:0] ep_tgt;
    logic [31:0] e_pt;
    logic [31:0] e_ptgt;
    logic [31:0] e_red;
    logic [31:0] e_rpc;
    logic [31:0] e_bcnt;
    logic [31:0] e_mcnt;
  } vec_t;

  vec_t vecs[$];

  localparam logic [31:0] N  = 32'd0;
  localparam logic [31:0] JR = 32'd1;
  localparam logic [31:0] B  = 32'd2;
  localparam logic [31:0] J  = 32'd3;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [31:0] if_pc, valid, br, zero, ex_pc, ex_tgt,
                     ep_taken, ep_tgt, e_pt, e_ptgt, e_red, e_rpc, e_bcnt, e_mcnt);
    vec_t v;
    v.if_pc = if_pc;   v.valid = valid;     v.br = br;         v.zero = zero;
    v.ex_pc = ex_pc;   v.ex_tgt = ex_tgt;   v.ep_taken = ep_taken;
    v.ep_tgt = ep_tgt; v.e_pt = e_pt;       v.e_ptgt = e_ptgt; v.e_red = e_red;
    v.e_rpc = e_rpc;   v.e_bcnt = e_bcnt;   v.e_mcnt = e_mcnt;
    vecs.push_back(v);
  endtask

  task automatic drive_ex(input logic v, input logic s, input logic [1:0] br, input logic z,
                          input logic [31:0] pc, input logic [31:0] tgt,
                          input logic ept, input logic [31:0] eptgt);
    bus.ex_valid       = v;
    bus.ex_stall       = s;
    bus.ex_branch      = br;
    bus.ex_zero_flag   = z;
    bus.ex_pc          = pc;
    bus.ex_target      = tgt;
    bus.ex_pred_taken  = ept;
    bus.ex_pred_target = eptgt;
  endtask

  task automatic ex_idle();
    drive_ex(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
  endtask

  initial begin
    rst_n    = 1'b0;
    sc_rst_n = 1'b0;
    sc_inc   = 1'b0;
    bus.if_pc = 32'h100;
    ex_idle();

    //   if_pc  val br zero ex_pc   ex_tgt  ept ep_tgt  | pt ptgt    red rpc     bcnt mcnt
    add(32'h100, 0, N, 0, 32'h000, 32'h000, 0, 32'h000,  0, 32'h104, 0, 32'h0,   0,  0);
    add(32'h100, 1, B, 1, 32'h100, 32'h180, 0, 32'h104,  0, 32'h104, 1, 32'h180, 0,  0);
    add(32'h100, 0, N, 0, 32'h000, 32'h000, 0, 32'h000,  1, 32'h180, 0, 32'h0,   1,  1);
    add(32'h100, 1, B, 0, 32'h100, 32'h180, 1, 32'h180,  1, 32'h180, 1, 32'h104, 1,  1);
    add(32'h100, 1, B, 0, 32'h100, 32'h180, 0, 32'h104,  0, 32'h104, 0, 32'h104, 2,  2);
    add(32'h100, 1, B, 0, 32'h100, 32'h180, 0, 32'h104,  0, 32'h104, 0, 32'h104, 3,  2);
    add(32'h100, 1, B, 0, 32'h100, 32'h180, 0, 32'h104,  0, 32'h104, 0, 32'h104, 4,  2);
    add(32'h100, 1, B, 0, 32'h100, 32'h180, 0, 32'h104,  0, 32'h104, 0, 32'h104, 5,  2);
    add(32'h100, 0, N, 0, 32'h000, 32'h000, 0, 32'h000,  0, 32'h104, 0, 32'h0,   6,  2);
    add(32'h100, 1, B, 1, 32'h100, 32'h180, 0, 32'h104,  0, 32'h104, 1, 32'h180, 6,  2);
    add(32'h100, 0, N, 0, 32'h000, 32'h000, 0, 32'h000,  0, 32'h104, 0, 32'h0,   7,  3);
    add(32'h200, 1, JR,0, 32'h200, 32'h300, 0, 32'h204,  0, 32'h204, 1, 32'h300, 7,  3);
    add(32'h200, 1, JR,0, 32'h200, 32'h340, 1, 32'h300,  1, 32'h300, 1, 32'h340, 8,  4);
    add(32'h200, 0, N, 0, 32'h000, 32'h000, 0, 32'h000,  1, 32'h340, 0, 32'h0,   9,  5);
    add(32'h100, 1, JR,0, 32'h200, 32'h340, 1, 32'h340,  0, 32'h104, 0, 32'h340, 9,  5);
    add(32'h100, 1, B, 1, 32'h100, 32'h180, 0, 32'h104,  0, 32'h104, 1, 32'h180, 10, 5);
    add(32'h100, 1, J, 0, 32'h140, 32'h500, 0, 32'h144,  1, 32'h180, 1, 32'h500, 11, 6);
    add(32'h100, 0, N, 0, 32'h000, 32'h000, 0, 32'h000,  0, 32'h104, 0, 32'h0,   12, 7);
    add(32'h140, 0, J, 1, 32'h140, 32'h999, 0, 32'h144,  1, 32'h500, 0, 32'h0,   12, 7);
    add(32'h140, 0, N, 0, 32'h000, 32'h000, 0, 32'h000,  1, 32'h500, 0, 32'h0,   12, 7);
    add(32'h108, 1, B, 1, 32'h108, 32'h400, 0, 32'h10c,  0, 32'h10c, 1, 32'h400, 12, 7);
    add(32'h108, 1, B, 1, 32'h108, 32'h400, 0, 32'h10c,  1, 32'h400, 1, 32'h400, 13, 8);
    add(32'h108, 1, B, 1, 32'h108, 32'h400, 1, 32'h400,  1, 32'h400, 0, 32'h400, 14, 9);
    add(32'h108, 1, B, 0, 32'h108, 32'h400, 1, 32'h400,  1, 32'h400, 1, 32'h10c, 15, 9);
    add(32'h108, 0, N, 0, 32'h000, 32'h000, 0, 32'h000,  1, 32'h400, 0, 32'h0,   16, 10);

    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Table-driven section: one record per cycle
    foreach (vecs[k]) begin
      @(negedge clk);
      bus.if_pc = vecs[k].if_pc;
      drive_ex(vecs[k].valid[0], 1'b0, vecs[k].br[1:0], vecs[k].zero[0],
               vecs[k].ex_pc, vecs[k].ex_tgt, vecs[k].ep_taken[0], vecs[k].ep_tgt);
      #1;
      $display("[TB] vec %0d if_pc=0x%0h pred=%0b/0x%0h redirect=%0b/0x%0h cnt=%0d/%0d",
               k, bus.if_pc, bus.pred_taken, bus.pred_target, bus.redirect,
               bus.redirect_pc, bus.branch_cnt, bus.mispred_cnt);
      check($sformatf("v%0d pred_taken", k), {31'd0, bus.pred_taken}, vecs[k].e_pt);
      check($sformatf("v%0d pred_target", k), bus.pred_target, vecs[k].e_ptgt);
      check($sformatf("v%0d redirect", k), {31'd0, bus.redirect}, vecs[k].e_red);
      if (vecs[k].valid[0] && (vecs[k].br != N)) begin
        check($sformatf("v%0d redirect_pc", k), bus.redirect_pc, vecs[k].e_rpc);
      end
      check($sformatf("v%0d branch_cnt", k), bus.branch_cnt, vecs[k].e_bcnt);
      check($sformatf("v%0d mispred_cnt", k), bus.mispred_cnt, vecs[k].e_mcnt);
    end

    // Stalled jal: held three cycles, resolves once when released
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      bus.if_pc = 32'h300;
      drive_ex(1'b1, 1'b1, 2'b11, 1'b0, 32'h300, 32'h600, 1'b0, 32'h304);
      #1;
      $display("[TB] stall cycle %0d redirect=%0b branch_cnt=%0d", c, bus.redirect, bus.branch_cnt);
      check($sformatf("stall%0d redirect", c), {31'd0, bus.redirect}, 32'd0);
      check($sformatf("stall%0d branch_cnt", c), bus.branch_cnt, 32'd16);
      check($sformatf("stall%0d pred_taken", c), {31'd0, bus.pred_taken}, 32'd0);
    end
    @(negedge clk);
    bus.ex_stall = 1'b0;
    #1;
    $display("[TB] unstall redirect=%0b redirect_pc=0x%0h", bus.redirect, bus.redirect_pc);
    check("unstall redirect", {31'd0, bus.redirect}, 32'd1);
    check("unstall redirect_pc", bus.redirect_pc, 32'h600);
    @(negedge clk);
    ex_idle();
    #1;
    $display("[TB] after unstall cnt=%0d/%0d pred=%0b/0x%0h", bus.branch_cnt, bus.mispred_cnt,
             bus.pred_taken, bus.pred_target);
    check("unstall branch_cnt", bus.branch_cnt, 32'd17);
    check("unstall mispred_cnt", bus.mispred_cnt, 32'd11);
    check("jal alloc pred_taken", {31'd0, bus.pred_taken}, 32'd1);
    check("jal alloc pred_target", bus.pred_target, 32'h600);
    @(negedge clk);
    #1;
    check("single resolve branch_cnt", bus.branch_cnt, 32'd17);

    // Reset with a resolving jal in EX: update dropped, everything cleared
    @(negedge clk);
    rst_n = 1'b0;
    bus.if_pc = 32'h700;
    drive_ex(1'b1, 1'b0, 2'b11, 1'b0, 32'h700, 32'h800, 1'b0, 32'h704);
    @(negedge clk);
    rst_n = 1'b1;
    ex_idle();
    #1;
    $display("[TB] post-reset pred=%0b/0x%0h redirect=%0b cnt=%0d/%0d", bus.pred_taken,
             bus.pred_target, bus.redirect, bus.branch_cnt, bus.mispred_cnt);
    check("rst pred_taken 0x700", {31'd0, bus.pred_taken}, 32'd0);
    check("rst pred_target 0x700", bus.pred_target, 32'h704);
    check("rst redirect", {31'd0, bus.redirect}, 32'd0);
    check("rst branch_cnt", bus.branch_cnt, 32'd0);
    check("rst mispred_cnt", bus.mispred_cnt, 32'd0);
    bus.if_pc = 32'h300;
    #1;
    check("rst pred_taken 0x300", {31'd0, bus.pred_taken}, 32'd0);
    bus.if_pc = 32'h108;
    #1;
    check("rst pred_taken 0x108", {31'd0, bus.pred_taken}, 32'd0);
    check("rst pred_target 0x108", bus.pred_target, 32'h10c);

    // Narrow counter: saturates at all-ones, clear beats increment
    @(negedge clk);
    sc_rst_n = 1'b1;
    sc_inc   = 1'b1;
    repeat (3) @(negedge clk);
    $display("[TB] sat_counter after 3 incs = %0d", sc_count);
    check("sat_counter 3", {29'd0, sc_count}, 32'd3);
    repeat (7) @(negedge clk);
    $display("[TB] sat_counter after 10 incs = %0d", sc_count);
    check("sat_counter saturate", {29'd0, sc_count}, 32'd7);
    sc_rst_n = 1'b0;
    @(negedge clk);
    $display("[TB] sat_counter after clear = %0d", sc_count);
    check("sat_counter clear", {29'd0, sc_count}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
